icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetch unit and the memory controller's icache port.
- One line holds one 32-bit instruction (4 bytes).
- Hits return in 1 cycle.
- Misses fill byte-by-byte over the 8-bit memory path. The controller can pre-empt the path for dcache traffic at any cycle.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines). Tag width = 16 - INDEX_BITS.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; sampled only when if_ready=1
- if_addr  in  18  fetch byte address; bits [1:0] ignored
- if_ready  out  1  cache can accept a request (state IDLE)
- out_valid  out  1  one-cycle pulse; out_inst valid
- out_inst  out  32  instruction, little-endian (byte 0 in [7:0])
- flush  in  1  cancel the outstanding fetch (mispredict); cache contents kept
- inv  in  1  clear all valid bits (fence.i)
- mem_rw_en  out  1  read request to controller (icache_rw_en)
- mem_addr  out  18  byte address to controller (icache_addr)
- mem_grant  in  1  controller icache_out_en: mem_addr is issued to memory this cycle
- mem_din  in  8  controller icache_out_data: byte for the address granted in the previous cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE, all valid bits 0, counters 0, if_ready=1, out_valid=0, out_inst=0, mem_rw_en=0, mem_addr=0. Reset mid-fill drops mem_rw_en immediately and discards the partial line.
- Address split: index = if_addr[INDEX_BITS+1:2]; tag = if_addr[17:INDEX_BITS+2]. The request address is latched on accept.
- IDLE: if_req=1 and flush=0 accepts the request.
  - Hit (valid and tag match): RESP next cycle.
  - Miss: FILL next cycle, with issue_cnt=0 and recv_cnt=0.
- FILL:
  - mem_rw_en = (issue_cnt<4) and not flush, driven combinationally.
  - mem_addr = {tag, index, issue_cnt[1:0]}.
  - mem_grant=1 with issue_cnt<4: record pending byte index issue_cnt, then issue_cnt++.
  - mem_grant=0: address held, no advance.
  - mem_grant=1 with issue_cnt==4: ignored. This is a stale grant caused by the controller's registered enable.
  - Cycle after a recorded grant: mem_din is written to line byte[pending index], then recv_cnt++.
  - recv_cnt reaching 4: write data, tag and valid=1 into the array; go to RESP.
- RESP: out_valid=1 for exactly one cycle with out_inst = line data; then IDLE.
- if_ready=1 only in IDLE. mem_grant in IDLE/RESP is ignored.
- Uncontended miss timing: request accepted at t0, FILL t1, grants t2-t5, bytes captured t3-t6, out_valid t7. Each cycle of grant denial adds 1.
- Hit timing: request at t0, out_valid at t1.
- flush:
  - In FILL: abort, mem_rw_en low that same cycle, line not written, return to IDLE next cycle. Byte data returning later is ignored.
  - In RESP: out_valid suppressed, return to IDLE.
  - In IDLE: the request that cycle is not accepted.
- inv clears all valid bits on the next edge, in any state.
  - In IDLE with a simultaneous if_req, the lookup sees the pre-inv array. A hit is served; subsequent lookups miss.
  - A fill completing after inv still sets its own line valid.
  - inv and fill completion on the same edge: the filled line ends valid.
- Replacement: a fill overwrites the indexed line unconditionally. Writes to instruction memory are not snooped; software issues fence.i (inv).

Test Plan:
- Reset, memory word 0x00000093 at 0x00100, fetch 0x00100 -> mem_addr 0x00100-0x00103 on grant cycles t2-t5; out_valid at t7 with out_inst=0x00000093. Refetch 0x00100 -> out_valid next cycle, mem_rw_en stays 0.
- Miss on 0x00200 with mem_grant forced low on cycles t3-t4 (dcache busy) -> mem_addr held at 0x00201 while grant low; no duplicate byte writes; out_valid at t9 with correct word.
- Conflict: fill 0x00000 then 0x00100 (same index, INDEX_BITS=6) -> second is a miss. Refetch 0x00000 -> miss again, fetched from memory.
- flush asserted at t4 of a miss on 0x00300 -> mem_rw_en low at t4, no out_valid. Immediate refetch of 0x00300 -> full miss (line not valid), correct data.
- Cache 0x00100, pulse inv, refetch 0x00100 -> miss path (out_valid after 7 cycles).
- rst_n pulsed low at t3 of a fill -> mem_rw_en=0 and if_ready=1 asynchronously. Previously cached lines all miss after reset.

Source files
------------

// File: rtl/icache_if.sv
// icache_if: fetch-side request/response and memory-controller byte path.
// master = fetch unit + controller side, slave = the cache.
interface icache_if;
    logic        if_req;
    logic [17:0] if_addr;
    logic        if_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic        flush;
    logic        inv;
    logic        mem_rw_en;
    logic [17:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_din;

    modport master (
        output if_req,
        output if_addr,
        input  if_ready,
        input  out_valid,
        input  out_inst,
        output flush,
        output inv,
        input  mem_rw_en,
        input  mem_addr,
        output mem_grant,
        output mem_din
    );

    modport slave (
        input  if_req,
        input  if_addr,
        output if_ready,
        output out_valid,
        output out_inst,
        input  flush,
        input  inv,
        output mem_rw_en,
        output mem_addr,
        input  mem_grant,
        input  mem_din
    );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, one 32-bit word per line.
// Ports: clk, rst_n (async, active-low), bus (icache_if.slave: fetch + memory).
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic    clk,
    input  logic    rst_n,
    icache_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 16 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_arr  [LINES];
    logic [31:0]         data_arr [LINES];

    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic [2:0]            issue_cnt_q, issue_cnt_d;
    logic [2:0]            recv_cnt_q, recv_cnt_d;
    logic                  pend_q, pend_d;
    logic [1:0]            pend_idx_q, pend_idx_d;
    logic [31:0]           line_q, line_d;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  addr_unused;
    logic                  accept;
    logic                  hit;
    logic                  in_fill;
    logic                  grant_ok;
    logic                  fill_done;

    assign req_idx     = bus.if_addr[INDEX_BITS+1:2];
    assign req_tag     = bus.if_addr[17:INDEX_BITS+2];
    assign addr_unused = ^bus.if_addr[1:0];

    // Lookup uses the array as it stands this cycle, so an inv on the
    // same edge does not hide a hit.
    assign hit    = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign accept = (state_q == S_IDLE) && bus.if_req && !bus.flush;

    // flush aborts the fill outright: no grant is taken, no byte stored.
    assign in_fill  = (state_q == S_FILL) && !bus.flush;
    // Grants after the fourth issue are stale echoes of the
    // controller's registered enable.
    assign grant_ok = in_fill && bus.mem_grant && (issue_cnt_q < 3'd4);
    assign fill_done = in_fill && pend_q && (recv_cnt_q == 3'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = hit ? S_RESP : S_FILL;
                end
            end
            S_FILL: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (fill_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.if_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_RESP) && !bus.flush;
        bus.out_inst  = line_q;
        bus.mem_rw_en = (state_q == S_FILL) && !bus.flush &&
                        (issue_cnt_q < 3'd4);
        bus.mem_addr  = '0;
        if (state_q == S_FILL) begin
            bus.mem_addr = {tag_q, idx_q, issue_cnt_q[1:0]};
        end
    end

    always_comb begin
        tag_d       = tag_q;
        idx_d       = idx_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        pend_d      = 1'b0;
        pend_idx_d  = pend_idx_q;
        line_d      = line_q;
        if (accept) begin
            tag_d       = req_tag;
            idx_d       = req_idx;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            if (hit) begin
                line_d = data_arr[req_idx];
            end
        end
        if (grant_ok) begin
            pend_d      = 1'b1;
            pend_idx_d  = issue_cnt_q[1:0];
            issue_cnt_d = issue_cnt_q + 3'd1;
        end
        // The byte on mem_din belongs to the grant of the previous cycle.
        if (in_fill && pend_q) begin
            line_d[{pend_idx_q, 3'b000} +: 8] = bus.mem_din;
            recv_cnt_d = recv_cnt_q + 3'd1;
        end
    end

    // A completing fill wins over a simultaneous inv for its own line.
    always_comb begin
        valid_d = bus.inv ? '0 : valid_q;
        if (fill_done) begin
            valid_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            tag_q       <= '0;
            idx_q       <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            line_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            line_q      <= line_d;
        end
    end

    // Tag/data storage needs no reset; valid_q gates every use.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_arr[idx_q]  <= tag_q;
            data_arr[idx_q] <= line_d;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized and directed checks of icache against a
// line-level reference model and a registered-grant memory controller.
module tb_icache;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_if bus();

    icache #(.INDEX_BITS(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] mem [0:262143];
    bit         mvalid [64];
    logic [9:0] mtag [64];

    logic        s_ready, s_ov, s_rw, s_grant;
    logic [31:0] s_inst;
    logic [17:0] s_addr;

    // One clock: sample outputs at negedge, then act as the controller:
    // grant follows last cycle's enable, data follows last cycle's grant.
    task automatic tick();
        @(negedge clk);
        s_ready = bus.if_ready;
        s_ov    = bus.out_valid;
        s_inst  = bus.out_inst;
        s_rw    = bus.mem_rw_en;
        s_grant = bus.mem_grant;
        s_addr  = bus.mem_addr;
        @(posedge clk);
        #1;
        bus.mem_din   = s_grant ? mem[s_addr] : 8'($urandom);
        bus.mem_grant = s_rw;
    endtask

    function automatic logic [31:0] mword(logic [17:0] a);
        int b;
        b = int'({a[17:2], 2'b00});
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    function automatic bit m_hit(logic [17:0] a);
        return mvalid[a[7:2]] && (mtag[a[7:2]] == a[17:8]);
    endfunction

    function automatic void m_upd(logic [17:0] a, bit hit, bit abrt, bit iv);
        if (iv) foreach (mvalid[i]) mvalid[i] = 1'b0;
        if (!hit && !abrt) begin
            mvalid[a[7:2]] = 1'b1;
            mtag[a[7:2]]   = a[17:8];
        end
    endfunction

    function automatic void m_clear();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endfunction

    // Miss timing from the rules: grants possible from t2 on, skipping
    // denied cycles; response two cycles after the fourth grant.
    function automatic int miss_lat(logic [63:0] dm);
        int c;
        int n;
        c = 2;
        n = 0;
        while (n < 4 && c < 60) begin
            if (!dm[c]) n++;
            c++;
        end
        return c + 1;
    endfunction

    task automatic do_fetch(
        input  logic [17:0] a,
        input  logic [63:0] dm,
        input  int          fl,
        input  int          iv,
        output int          lat,
        output logic [31:0] word,
        output int          ng,
        output bit          aok,
        output bit          rws,
        output bit          rwf
    );
        lat  = -1;
        word = '0;
        ng   = 0;
        aok  = 1'b1;
        rws  = 1'b0;
        rwf  = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        bus.flush   = (fl == 0);
        bus.inv     = (iv == 0);
        if (dm[0]) bus.mem_grant = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (s_rw) rws = 1'b1;
            if (k == fl && s_rw) rwf = 1'b1;
            if (s_rw && s_addr !== {a[17:2], 2'(ng)}) aok = 1'b0;
            if (s_grant && s_rw) ng++;
            if (s_ov && lat < 0) begin
                lat  = k;
                word = s_inst;
            end
            bus.if_req = 1'b0;
            bus.flush  = (k + 1 == fl);
            bus.inv    = (k + 1 == iv);
            if (dm[k+1]) bus.mem_grant = 1'b0;
            if (lat >= 0) break;
            if (fl >= 0 && k >= fl + 3) break;
        end
        bus.flush = 1'b0;
        bus.inv   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_if_ready: got %b want 1", bus.if_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_inst: got %h want 0", bus.out_inst);
        end
        n_checks++;
        if (bus.mem_rw_en !== 1'b0 || bus.mem_addr !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_mem: rw %b addr %h want 0 0",
                     bus.mem_rw_en, bus.mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        tick();
    endtask

    task automatic test_basic();
        int lat, ng;
        logic [31:0] w;
        bit aok, rws, rwf;
        do_fetch(18'h00100, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        n_checks++;
        if (lat !== 7) begin
            n_fail++;
            $display("FAIL basic_miss_lat: got %0d want 7", lat);
        end
        n_checks++;
        if (w !== 32'h00000093) begin
            n_fail++;
            $display("FAIL basic_miss_data: got %h want 00000093", w);
        end
        n_checks++;
        if (ng !== 4 || !aok) begin
            n_fail++;
            $display("FAIL basic_miss_addr: grants %0d ok %0d want 4 1",
                     ng, aok);
        end
        m_upd(18'h00100, 1'b0, 1'b0, 1'b0);
        do_fetch(18'h00100, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        n_checks++;
        if (lat !== 1 || w !== 32'h00000093) begin
            n_fail++;
            $display("FAIL basic_hit: lat %0d data %h want 1 00000093",
                     lat, w);
        end
        n_checks++;
        if (rws !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hit_rw: got %b want 0", rws);
        end
    endtask

    task automatic test_grant_stall();
        int lat, ng;
        logic [31:0] w;
        bit aok, rws, rwf;
        logic [63:0] dm;
        dm = '0;
        dm[3] = 1'b1;
        dm[4] = 1'b1;
        do_fetch(18'h00200, dm, -1, -1, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00200, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL stall_lat: got %0d want 9", lat);
        end
        n_checks++;
        if (w !== mword(18'h00200)) begin
            n_fail++;
            $display("FAIL stall_data: got %h want %h", w, mword(18'h00200));
        end
        n_checks++;
        if (ng !== 4 || !aok) begin
            n_fail++;
            $display("FAIL stall_addr_hold: grants %0d ok %0d want 4 1",
                     ng, aok);
        end
    endtask

    task automatic test_conflict();
        int lat, ng;
        logic [31:0] w;
        bit aok, rws, rwf;
        logic [17:0] seq [3];
        seq[0] = 18'h00000;
        seq[1] = 18'h00100;
        seq[2] = 18'h00000;
        for (int i = 0; i < 3; i++) begin
            do_fetch(seq[i], '0, -1, -1, lat, w, ng, aok, rws, rwf);
            n_checks++;
            if (lat !== 7 || w !== mword(seq[i])) begin
                n_fail++;
                $display("FAIL conflict_%0d: lat %0d data %h want 7 %h",
                         i, lat, w, mword(seq[i]));
            end
            m_upd(seq[i], 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_flush();
        int lat, ng;
        logic [31:0] w;
        bit aok, rws, rwf;
        do_fetch(18'h00300, '0, 4, -1, lat, w, ng, aok, rws, rwf);
        n_checks++;
        if (rwf !== 1'b0 || lat !== -1) begin
            n_fail++;
            $display("FAIL flush_fill: rw %b lat %0d want 0 -1", rwf, lat);
        end
        do_fetch(18'h00300, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00300, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (lat !== 7 || w !== mword(18'h00300)) begin
            n_fail++;
            $display("FAIL flush_refetch: lat %0d data %h want 7 %h",
                     lat, w, mword(18'h00300));
        end
        do_fetch(18'h00300, '0, 1, -1, lat, w, ng, aok, rws, rwf);
        n_checks++;
        if (lat !== -1) begin
            n_fail++;
            $display("FAIL flush_resp: lat %0d want -1", lat);
        end
        do_fetch(18'h00300, '0, 0, -1, lat, w, ng, aok, rws, rwf);
        n_checks++;
        if (lat !== -1 || rws !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: lat %0d rw %b want -1 0", lat, rws);
        end
        do_fetch(18'h00300, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        n_checks++;
        if (lat !== 1 || w !== mword(18'h00300)) begin
            n_fail++;
            $display("FAIL flush_kept_line: lat %0d data %h want 1 %h",
                     lat, w, mword(18'h00300));
        end
    endtask

    task automatic test_inv();
        int lat, ng;
        logic [31:0] w;
        bit aok, rws, rwf;
        do_fetch(18'h00100, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00100, m_hit(18'h00100), 1'b0, 1'b0);
        bus.inv = 1'b1;
        tick();
        bus.inv = 1'b0;
        m_clear();
        do_fetch(18'h00100, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00100, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (lat !== 7 || w !== 32'h00000093) begin
            n_fail++;
            $display("FAIL inv_pulse: lat %0d data %h want 7 00000093",
                     lat, w);
        end
        do_fetch(18'h00100, '0, -1, 0, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00100, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL inv_same_hit: lat %0d want 1", lat);
        end
        do_fetch(18'h00100, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00100, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (lat !== 7) begin
            n_fail++;
            $display("FAIL inv_after_hit: lat %0d want 7", lat);
        end
        do_fetch(18'h00404, '0, -1, 3, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00404, 1'b0, 1'b0, 1'b1);
        do_fetch(18'h00404, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        n_checks++;
        if (lat !== 1 || w !== mword(18'h00404)) begin
            n_fail++;
            $display("FAIL inv_mid_fill: lat %0d data %h want 1 %h",
                     lat, w, mword(18'h00404));
        end
        do_fetch(18'h00508, '0, -1, 6, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00508, 1'b0, 1'b0, 1'b1);
        do_fetch(18'h00508, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL inv_fill_same_edge: lat %0d want 1", lat);
        end
    endtask

    task automatic test_reset_mid_fill();
        int lat, ng;
        logic [31:0] w;
        bit aok, rws, rwf;
        bus.if_req  = 1'b1;
        bus.if_addr = 18'h00600;
        tick();
        bus.if_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.mem_rw_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_rw: got %b want 1", bus.mem_rw_en);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_rw_en !== 1'b0 || bus.if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: rw %b ready %b want 0 1",
                     bus.mem_rw_en, bus.if_ready);
        end
        bus.mem_grant = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        tick();
        do_fetch(18'h00100, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00100, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (lat !== 7 || w !== 32'h00000093) begin
            n_fail++;
            $display("FAIL rst_refetch: lat %0d data %h want 7 00000093",
                     lat, w);
        end
        do_fetch(18'h00404, '0, -1, -1, lat, w, ng, aok, rws, rwf);
        m_upd(18'h00404, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (lat !== 7) begin
            n_fail++;
            $display("FAIL rst_refetch2: lat %0d want 7", lat);
        end
    endtask

    task automatic test_random();
        int lat, ng, elat, fl, iv;
        logic [31:0] w;
        bit aok, rws, rwf, hit, abrt;
        logic [17:0] a;
        logic [63:0] dm;
        for (int n = 0; n < 40; n++) begin
            a = 18'(($urandom % 3) << 8) | 18'(($urandom % 4) << 2) |
                18'($urandom % 4);
            dm = '0;
            for (int b = 2; b < 30; b++) dm[b] = ($urandom % 4 == 0);
            fl = -1;
            iv = -1;
            if ($urandom % 8 == 0) fl = 3;
            else if ($urandom % 8 == 0) iv = 0;
            hit  = m_hit(a);
            abrt = !hit && (fl >= 0);
            elat = hit ? 1 : (abrt ? -1 : miss_lat(dm));
            do_fetch(a, dm, fl, iv, lat, w, ng, aok, rws, rwf);
            m_upd(a, hit, abrt, iv >= 0);
            n_checks++;
            if (lat !== elat) begin
                n_fail++;
                $display("FAIL rand_lat_%0d: addr %h got %0d want %0d",
                         n, a, lat, elat);
            end
            if (elat >= 0) begin
                n_checks++;
                if (w !== mword(a)) begin
                    n_fail++;
                    $display("FAIL rand_data_%0d: addr %h got %h want %h",
                             n, a, w, mword(a));
                end
            end
            n_checks++;
            if (hit ? (rws !== 1'b0) : (!abrt && (ng !== 4 || !aok))) begin
                n_fail++;
                $display("FAIL rand_mem_%0d: hit %b rw %b grants %0d ok %b",
                         n, hit, rws, ng, aok);
            end
        end
    endtask

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.flush     = 1'b0;
        bus.inv       = 1'b0;
        bus.mem_grant = 1'b0;
        bus.mem_din   = '0;
        for (int i = 0; i < 262144; i++) mem[i] = 8'($urandom);
        mem[18'h00100] = 8'h93;
        mem[18'h00101] = 8'h00;
        mem[18'h00102] = 8'h00;
        mem[18'h00103] = 8'h00;
        m_clear();
        test_reset();
        test_basic();
        test_grant_stall();
        test_conflict();
        test_flush();
        test_inv();
        test_reset_mid_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
